// File: rtl/reindeer_mem_read_responder_pkg.sv
// reindeer_mem_read_responder_pkg: shared widths, FSM states and request types
// for the fetch/data SRAM responder.
package reindeer_mem_read_responder_pkg;
   localparam int XLEN          = 32;
   localparam int PC_BITWIDTH   = 32;
   localparam int MEM_ADDR_BITS = 12;
   localparam int MEM_LAT_MAX   = 4;
   localparam int LAT_W         = $clog2(MEM_LAT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'b001,
      S_BUSY_FETCH = 3'b010,
      S_BUSY_DATA  = 3'b100
   } state_t;

   typedef struct packed {
      logic                     write;
      logic [MEM_ADDR_BITS-1:0] addr;
      logic [XLEN-1:0]          wdata;
      logic [3:0]               be;
   } data_req_t;
endpackage

// File: rtl/reindeer_req_slot.sv
// reindeer_req_slot: one-entry request holder; a new push overwrites, pop or flush empties.
// The eff_* view presents the incoming request in the same cycle it arrives.
module reindeer_req_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic         eff_valid,
   output logic [W-1:0] eff_data
);
   logic         held;
   logic [W-1:0] held_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         held      <= 1'b0;
         held_data <= '0;
      end else if (flush || pop) begin
         held      <= 1'b0;
      end else if (push) begin
         held      <= 1'b1;
         held_data <= push_data;
      end
   end

   assign eff_valid = (push || held) && !flush;
   assign eff_data  = push ? push_data : held_data;
endmodule

// File: rtl/reindeer_mem_read_responder.sv
// reindeer_mem_read_responder: arbitrates instruction fetches and load/stores onto one
// single-port SRAM; data beats fetch, and an issued access always runs to completion.
module reindeer_mem_read_responder
   import reindeer_mem_read_responder_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     sync_reset,
   input  logic                     read_mem_enable,
   input  logic [PC_BITWIDTH-1:0]   read_mem_addr,
   output logic                     mem_read_done,
   output logic [XLEN-1:0]          mem_data,
   output logic [MEM_ADDR_BITS-1:0] mem_addr_ack,
   output logic                     dram_rw_pending,
   input  logic                     data_rw_enable,
   input  logic                     data_write,
   input  logic [PC_BITWIDTH-1:0]   data_addr,
   input  logic [XLEN-1:0]          data_wdata,
   input  logic [3:0]               data_byte_en,
   output logic                     data_done,
   output logic [XLEN-1:0]          data_rdata,
   output logic                     sram_cs,
   output logic                     sram_we,
   output logic [MEM_ADDR_BITS-1:0] sram_addr,
   output logic [XLEN-1:0]          sram_wdata,
   output logic [3:0]               sram_be,
   input  logic [XLEN-1:0]          sram_rdata
);
   state_t                   state, state_n;
   logic [LAT_W-1:0]         lat_cnt, lat_n;
   logic                     idle, f_valid, d_valid, d_push, issue_f, issue_d, done_now;
   logic                     fin_f, fin_d;
   logic [MEM_ADDR_BITS-1:0] f_addr;
   data_req_t                d_in, d_req;
   logic                     addr_unused;

   assign addr_unused = ^{read_mem_addr, data_addr};
   assign d_push      = data_rw_enable && !dram_rw_pending;
   assign d_in        = '{write: data_write, addr: data_addr[MEM_ADDR_BITS+1:2],
                          wdata: data_wdata, be: data_byte_en};

   reindeer_req_slot #(.W(MEM_ADDR_BITS)) u_fetch_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (sync_reset),
      .push      (read_mem_enable),
      .pop       (issue_f),
      .push_data (read_mem_addr[MEM_ADDR_BITS+1:2]),
      .eff_valid (f_valid),
      .eff_data  (f_addr)
   );

   reindeer_req_slot #(.W($bits(data_req_t))) u_data_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (sync_reset),
      .push      (d_push),
      .pop       (issue_d),
      .push_data (d_in),
      .eff_valid (d_valid),
      .eff_data  (d_req)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         lat_cnt <= '0;
      end else begin
         state   <= state_n;
         lat_cnt <= lat_n;
      end
   end

   always_comb begin
      idle     = state == S_IDLE;
      issue_d  = idle && d_valid;
      issue_f  = idle && f_valid && !d_valid;
      done_now = !idle && lat_cnt == LAT_W'(READ_LATENCY);
      fin_f    = done_now && state == S_BUSY_FETCH && !sync_reset;
      fin_d    = done_now && state == S_BUSY_DATA && !sync_reset;
      lat_n    = idle ? '0 : lat_cnt + LAT_W'(1);
      state_n  = sync_reset ? S_IDLE :
                 issue_d    ? S_BUSY_DATA :
                 issue_f    ? S_BUSY_FETCH :
                 done_now   ? S_IDLE : state;
   end

   // SRAM-side registers hold their last access; sync_reset only stops new issue and done pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sram_cs         <= 1'b0;
         sram_we         <= 1'b0;
         sram_addr       <= '0;
         sram_wdata      <= '0;
         sram_be         <= '0;
         mem_read_done   <= 1'b0;
         mem_data        <= '0;
         mem_addr_ack    <= '0;
         data_done       <= 1'b0;
         data_rdata      <= '0;
         dram_rw_pending <= 1'b0;
      end else begin
         sram_cs       <= issue_d || issue_f;
         mem_read_done <= fin_f;
         data_done     <= fin_d;
         if (issue_d) begin
            sram_we    <= d_req.write;
            sram_addr  <= d_req.addr;
            sram_wdata <= d_req.wdata;
            sram_be    <= d_req.be;
         end else if (issue_f) begin
            sram_we    <= 1'b0;
            sram_addr  <= f_addr;
            sram_be    <= 4'hF;
         end
         if (fin_f) begin
            mem_data     <= sram_rdata;
            mem_addr_ack <= sram_addr;
         end
         if (fin_d)
            data_rdata <= sram_rdata;
         dram_rw_pending <= sync_reset ? 1'b0 :
                            d_push     ? 1'b1 :
                            data_done  ? 1'b0 : dram_rw_pending;
      end
   end

   a_no_data_req_while_pending: assert property (@(posedge clk) disable iff (!reset_n)
      !(data_rw_enable && dram_rw_pending && !sync_reset));
endmodule

// File: tb/tb_reindeer_mem_read_responder.sv
// tb_reindeer_mem_read_responder: randomized + directed scoreboard bench with SRAM models
// for a READ_LATENCY=1 instance and a fetch-only READ_LATENCY=4 instance.
module tb_reindeer_mem_read_responder;
   import reindeer_mem_read_responder_pkg::*;
   localparam int AW   = MEM_ADDR_BITS;
   localparam int LAT  = 1;
   localparam int LAT4 = 4;

   typedef struct {
      int          due;
      logic [AW-1:0] ack;
      logic [31:0] data;
      logic        chk;
   } exp_t;

   logic clk = 0, reset_n = 0, reset_n4 = 0, sync_reset = 0;
   logic read_mem_enable = 0, data_rw_enable = 0, data_write = 0;
   logic [31:0] read_mem_addr = 0, data_addr = 0, data_wdata = 0;
   logic [3:0]  data_byte_en = 0;
   logic mem_read_done, dram_rw_pending, data_done, sram_cs, sram_we;
   logic [31:0] mem_data, data_rdata, sram_wdata, sram_rdata;
   logic [AW-1:0] mem_addr_ack, sram_addr;
   logic [3:0] sram_be;

   logic r4_en = 0, zero = 0;
   logic [31:0] r4_addr = 0, z32 = 0;
   logic [3:0] z4 = 0;
   logic done4, pend4, dd4, cs4, we4;
   logic [31:0] mdata4, drd4, wd4, rd4;
   logic [AW-1:0] ack4, a4;
   logic [3:0] be4;

   int cyc = 0, total = 0, bad = 0, n_fdone = 0, n_ddone = 0, pend_from = 1, pend_to = 0;
   exp_t fetch_q[$], data_q[$], f4_q[$];
   logic [31:0] mem [2**AW];
   logic [31:0] ref_mem [2**AW];
   logic [31:0] p1;
   logic [31:0] p4 [LAT4];

   reindeer_mem_read_responder #(.READ_LATENCY(LAT)) dut (
      .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
      .read_mem_enable(read_mem_enable), .read_mem_addr(read_mem_addr),
      .mem_read_done(mem_read_done), .mem_data(mem_data), .mem_addr_ack(mem_addr_ack),
      .dram_rw_pending(dram_rw_pending), .data_rw_enable(data_rw_enable),
      .data_write(data_write), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_byte_en(data_byte_en), .data_done(data_done), .data_rdata(data_rdata),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_be(sram_be), .sram_rdata(sram_rdata)
   );

   reindeer_mem_read_responder #(.READ_LATENCY(LAT4)) dut4 (
      .clk(clk), .reset_n(reset_n4), .sync_reset(zero),
      .read_mem_enable(r4_en), .read_mem_addr(r4_addr),
      .mem_read_done(done4), .mem_data(mdata4), .mem_addr_ack(ack4),
      .dram_rw_pending(pend4), .data_rw_enable(zero),
      .data_write(zero), .data_addr(z32), .data_wdata(z32),
      .data_byte_en(z4), .data_done(dd4), .data_rdata(drd4),
      .sram_cs(cs4), .sram_we(we4), .sram_addr(a4),
      .sram_wdata(wd4), .sram_be(be4), .sram_rdata(rd4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(int i);
      return 32'(i) * 32'h9E3779B1 ^ 32'hC3A50F1E;
   endfunction

   function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
      end
   endfunction

   // SRAM models: read data is only valid exactly READ_LATENCY cycles after sram_cs
   initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         p1 <= sram_cs ? mem[sram_addr] : 32'hDEADBEEF;
         if (sram_cs && sram_we)
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
      end
   end
   assign sram_rdata = p1;

   initial forever begin
      @(posedge clk);
      p4[0] <= cs4 ? mem[a4] : 32'hDEADBEEF;
      for (int i = 1; i < LAT4; i++) p4[i] <= p4[i-1];
   end
   assign rd4 = p4[LAT4-1];

   always @(negedge clk) begin : mon
      exp_t e;
      if (reset_n) begin
         chk("pending", 32'(dram_rw_pending), 32'(cyc >= pend_from && cyc <= pend_to));
         if (mem_read_done) begin
            n_fdone++;
            if (fetch_q.size() == 0) begin
               total++; bad++;
               $display("FAIL fetch_spurious cyc=%0d got done=1 want done=0", cyc);
            end else begin
               e = fetch_q.pop_front();
               chk("fetch_cycle", 32'(cyc), 32'(e.due));
               chk("fetch_ack", 32'(mem_addr_ack), 32'(e.ack));
               chk("fetch_data", mem_data, e.data);
            end
         end
         if (data_done) begin
            n_ddone++;
            if (data_q.size() == 0) begin
               total++; bad++;
               $display("FAIL data_spurious cyc=%0d got done=1 want done=0", cyc);
            end else begin
               e = data_q.pop_front();
               chk("data_cycle", 32'(cyc), 32'(e.due));
               if (e.chk) chk("load_data", data_rdata, e.data);
            end
         end
      end
   end

   always @(negedge clk) begin : mon4
      exp_t e;
      if (reset_n4 && done4) begin
         if (f4_q.size() == 0) begin
            total++; bad++;
            $display("FAIL l4_spurious cyc=%0d got done=1 want done=0", cyc);
         end else begin
            e = f4_q.pop_front();
            chk("l4_cycle", 32'(cyc), 32'(e.due));
            chk("l4_ack", 32'(ack4), 32'(e.ack));
            chk("l4_data", mdata4, e.data);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [AW-1:0] w, input logic [31:0] wd, input logic [3:0] be);
      for (int b = 0; b < 4; b++)
         if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
   endtask

   // one-cycle request on an idle responder; expectations follow data-before-fetch order
   task automatic req(input logic df, input logic [31:0] fa, input logic dd, input logic w,
                      input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be);
      exp_t e;
      int t;
      logic [AW-1:0] dw, fw;
      t  = cyc;
      dw = da[AW+1:2];
      fw = fa[AW+1:2];
      if (dd) begin
         if (w) store(dw, wd, be);
         e = '{t + 2 + LAT, dw, ref_mem[dw], !w};
         data_q.push_back(e);
         pend_from = t + 1;
         pend_to   = t + 2 + LAT;
      end
      if (df) begin
         e = '{dd ? t + 4 + 2*LAT : t + 2 + LAT, fw, ref_mem[fw], 1'b1};
         fetch_q.push_back(e);
      end
      read_mem_enable = df; read_mem_addr = fa;
      data_rw_enable = dd; data_write = w; data_addr = da; data_wdata = wd; data_byte_en = be;
      step();
      read_mem_enable = 0; data_rw_enable = 0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((fetch_q.size() + data_q.size() + f4_q.size()) != 0 && n < 200) begin
         step();
         n++;
      end
      if ((fetch_q.size() + data_q.size() + f4_q.size()) != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout cyc=%0d got outstanding=%0d want 0", cyc,
                  fetch_q.size() + data_q.size() + f4_q.size());
         fetch_q.delete(); data_q.delete(); f4_q.delete();
      end
      step();
   endtask

   initial begin
      int t, snap;
      logic [31:0] fa, da, wd;
      exp_t e;
      for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_word(i);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_main", 32'(|{mem_read_done, mem_data, mem_addr_ack, dram_rw_pending, data_done,
          data_rdata, sram_cs, sram_we, sram_addr, sram_wdata, sram_be}), 0);
      chk("rst_l4", 32'(|{done4, mdata4, ack4, pend4, dd4, drd4, cs4, we4, a4, wd4, be4}), 0);
      reset_n = 1; reset_n4 = 1;
      step();

      req(1, 32'h100, 0, 0, 0, 0, 0);
      chk("t1_cs", 32'(sram_cs), 1);
      chk("t1_addr", 32'(sram_addr), 32'h40);
      chk("t1_we", 32'(sram_we), 0);
      drain();

      req(1, 32'h200, 1, 0, 32'h300, 0, 0);
      drain();

      req(0, 0, 1, 1, 32'h10, 32'hA5A5A5A5, 4'b0011);
      drain();
      req(0, 0, 1, 0, 32'h10, 0, 0);
      drain();
      wd = init_word(4);
      chk("t3_merge", data_rdata, {wd[31:16], 16'hA5A5});

      t = cyc;
      e = '{t + 2 + LAT, AW'(0), ref_mem[0], 1'b1};
      fetch_q.push_back(e);
      e = '{t + 4 + 2*LAT, AW'('h20), ref_mem['h20], 1'b1};
      fetch_q.push_back(e);
      read_mem_enable = 1; read_mem_addr = 32'h0;
      step();
      read_mem_addr = 32'h40;
      step();
      read_mem_addr = 32'h80;
      step();
      read_mem_enable = 0;
      drain();

      t = cyc;
      snap = n_fdone + n_ddone;
      pend_from = t + 1; pend_to = t + 2;
      data_rw_enable = 1; data_write = 0; data_addr = 32'h24;
      step();
      data_rw_enable = 0;
      step();
      sync_reset = 1; read_mem_enable = 1; read_mem_addr = 32'h444;
      step();
      sync_reset = 0; read_mem_enable = 0;
      repeat (6) step();
      chk("t5_no_done", 32'(n_fdone + n_ddone - snap), 0);
      req(1, 32'h8, 0, 0, 0, 0, 0);
      drain();
      req(0, 0, 1, 0, 32'h24, 0, 0);
      drain();

      for (int it = 0; it < 60; it++) begin
         int kind;
         repeat ($urandom_range(0, 3)) step();
         kind = $urandom_range(0, 2);
         fa = $urandom; fa[AW+1:2] = AW'($urandom_range(0, 63));
         da = $urandom; da[AW+1:2] = AW'($urandom_range(0, 31));
         req(kind != 1, fa, kind != 0, 1'($urandom), da, $urandom, 4'($urandom));
         drain();
      end

      // latency-4 instance: continuous fetch stream, newest address wins at each issue
      t = cyc;
      for (int k = 1; k <= 4; k++) begin
         logic [AW-1:0] w;
         w = AW'(t + (k - 1) * (LAT4 + 2));
         e = '{t + k * (LAT4 + 2), w, ref_mem[w], 1'b1};
         f4_q.push_back(e);
      end
      r4_en = 1;
      for (int c = 0; c <= 3 * (LAT4 + 2); c++) begin
         r4_addr = 32'hF000_0000 | (32'(cyc) << 2);
         step();
      end
      r4_en = 0;
      drain();

      chk("l4_data_before", 32'(mdata4 != 0), 1);
      r4_en = 1; r4_addr = 32'h3FC;
      step();
      r4_en = 0;
      chk("l4_cs", 32'(cs4), 1);
      chk("l4_addr", 32'(a4), 32'hFF);
      step();
      #2;
      reset_n4 = 0;
      #1;
      chk("l4_async_clear", 32'(|{done4, mdata4, ack4, pend4, dd4, drd4, cs4, we4, a4, wd4, be4}), 0);
      step();
      reset_n4 = 1;
      repeat (8) step();
      t = cyc;
      e = '{t + 2 + LAT4, AW'('h55), ref_mem['h55], 1'b1};
      f4_q.push_back(e);
      r4_en = 1; r4_addr = 32'h154;
      step();
      r4_en = 0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
